// File: rtl/uart_pkg.sv
// uart_pkg: shared drain FSM state type and sizing constants for the UART transmit buffer
package uart_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} drain_state_t;
    localparam int DEPTH_LOG2_DEF = 4;
    localparam int ACK_TIMEOUT_DEF = 4;
    localparam int BYTE_W = 8;
endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: dual-port byte storage, synchronous write port, asynchronous read port
module uart_fifo_ram import uart_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int WIDTH = BYTE_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO ahead of uart_tx, drained one byte per frame via a we/busy handshake
module uart_tx_fifo import uart_pkg::*; #(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [BYTE_W-1:0]   wr_data,
    input  logic                flush,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow,
    output logic                uart_we,
    output logic [BYTE_W-1:0]   uart_data,
    input  logic                uart_busy
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [BYTE_W-1:0] head;
    logic [TW-1:0] timer;
    logic push, pop;
    drain_state_t state;
    // a flush cycle never starts a handoff, so no flushed byte can reach the line
    assign push = wr_en & ~full & ~flush;
    assign pop = (state == IDLE) & ~empty & ~uart_busy & ~flush;
    always_comb begin
        wr_nxt = flush ? '0 : wr_ptr + PW'(push);
        rd_nxt = flush ? '0 : rd_ptr + PW'(pop);
    end
    uart_fifo_ram #(.DEPTH(2 ** DEPTH_LOG2), .WIDTH(BYTE_W)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (head)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            count    <= wr_nxt - rd_nxt;
            empty    <= wr_nxt == rd_nxt;
            full     <= (wr_nxt[PW-1] != rd_nxt[PW-1]) && (wr_nxt[PW-2:0] == rd_nxt[PW-2:0]);
            overflow <= wr_en & full & ~flush;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            uart_we   <= 1'b0;
            uart_data <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    state     <= ISSUE;
                    uart_we   <= 1'b1;
                    uart_data <= head;
                end
                ISSUE: begin
                    state   <= WAIT_ACK;
                    uart_we <= 1'b0;
                    timer   <= '0;
                end
                WAIT_ACK: begin
                    if (uart_busy) state <= WAIT_DONE;
                    else if (timer == TW'(ACK_TIMEOUT - 1)) state <= IDLE;
                    else timer <= timer + TW'(1);
                end
                WAIT_DONE: if (!uart_busy) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: table vectors, directed corner sequences and a queue scoreboard for uart_tx_fifo
module tb_uart_tx_fifo;
    import uart_pkg::*;
    localparam int DL = 4;
    localparam int NV = 8;
    typedef struct {
        logic       we;
        logic       fl;
        logic [7:0] d;
        int         cnt;
        logic       emp;
        logic       ful;
        logic       ovf;
    } vec_t;
    logic clk = 0, reset = 0, wr_en = 0, flush = 0, force_busy = 0;
    logic [7:0] wr_data = 0;
    logic full, empty, overflow, uart_we, uart_busy;
    logic [DL:0] count;
    logic [7:0] uart_data;
    int stub_len = 0, stub_cnt = 0;
    int total = 0, bad = 0, we_cnt = 0;
    logic [7:0] q[$];
    logic m_we, m_fl, m_busy, m_ovf;
    logic [7:0] m_d, m_exp;
    vec_t tv [NV];

    always #5 clk = ~clk;
    assign uart_busy = force_busy | (stub_cnt != 0);

    uart_tx_fifo #(.DEPTH_LOG2(DL), .ACK_TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .uart_we   (uart_we),
        .uart_data (uart_data),
        .uart_busy (uart_busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // uart_tx stand-in: a start pulse holds busy for stub_len cycles (0 = never acknowledges)
    always @(negedge clk) begin
        if (!reset) stub_cnt = 0;
        else if (uart_we && stub_len > 0) stub_cnt = stub_len;
        else if (stub_cnt > 0) stub_cnt = stub_cnt - 1;
    end

    // scoreboard: occupancy is the number of accepted bytes not yet handed off
    always @(posedge clk) begin
        m_we = wr_en;
        m_fl = flush;
        m_d = wr_data;
        m_busy = uart_busy;
        #1;
        if (!reset) q.delete();
        else begin
            m_ovf = m_we && !m_fl && q.size() == 16;
            if (m_fl) q.delete();
            else if (m_we && q.size() < 16) q.push_back(m_d);
            if (uart_we) begin
                we_cnt++;
                chk("issue_while_busy", m_busy, 0);
                chk("issue_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    m_exp = q.pop_front();
                    chk("uart_data_order", uart_data, m_exp);
                end
            end
            chk("sb_count", count, q.size());
            chk("sb_empty", empty, q.size() == 0);
            chk("sb_full", full, q.size() == 16);
            chk("sb_overflow", overflow, m_ovf);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, peak, t1, t2, sent;
        logic ok;
        tv[0] = '{1, 0, 8'h11, 1, 0, 0, 0};
        tv[1] = '{1, 0, 8'h22, 2, 0, 0, 0};
        tv[2] = '{0, 0, 8'h00, 2, 0, 0, 0};
        tv[3] = '{1, 1, 8'hEE, 0, 1, 0, 0};
        tv[4] = '{0, 1, 8'h00, 0, 1, 0, 0};
        tv[5] = '{1, 0, 8'h33, 1, 0, 0, 0};
        tv[6] = '{1, 0, 8'h44, 2, 0, 0, 0};
        tv[7] = '{0, 1, 8'h00, 0, 1, 0, 0};
        repeat (3) @(negedge clk);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_we", uart_we, 0);
        chk("rst_data", uart_data, 0);
        reset = 1;
        force_busy = 1;
        for (int i = 0; i < NV; i++) begin
            wr_en = tv[i].we;
            flush = tv[i].fl;
            wr_data = tv[i].d;
            @(negedge clk);
            chk($sformatf("tv%0d_count", i), count, tv[i].cnt);
            chk($sformatf("tv%0d_empty", i), empty, tv[i].emp);
            chk($sformatf("tv%0d_full", i), full, tv[i].ful);
            chk($sformatf("tv%0d_ovf", i), overflow, tv[i].ovf);
        end
        wr_en = 0;
        flush = 0;
        force_busy = 0;
        repeat (5) @(negedge clk);

        wr_en = 1;
        wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 0;
        chk("lat_n1_we", uart_we, 0);
        chk("lat_n1_count", count, 1);
        @(negedge clk);
        chk("lat_n2_we", uart_we, 1);
        chk("lat_n2_data", uart_data, 8'hA5);
        chk("lat_n2_count", count, 0);
        chk("lat_n2_empty", empty, 1);
        @(negedge clk);
        chk("lat_n3_we", uart_we, 0);
        chk("lat_n3_data_hold", uart_data, 8'hA5);
        repeat (8) @(negedge clk);

        stub_len = 20;
        base = we_cnt;
        peak = 0;
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1;
            wr_data = 8'(i);
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
        end
        wr_en = 0;
        for (int j = 0; j < 200 && we_cnt - base < 3; j++) begin
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
        end
        repeat (30) @(negedge clk);
        chk("bb_pulses", we_cnt - base, 3);
        chk("bb_peak_range", peak >= 2 && peak <= 3, 1);

        stub_len = 3;
        force_busy = 1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                chk("fill_full16", full, 1);
                chk("fill_count16", count, 16);
            end
            wr_en = 1;
            wr_data = 8'h40 + 8'(i);
            @(negedge clk);
        end
        wr_en = 0;
        chk("fill_overflow", overflow, 1);
        chk("fill_count_hold", count, 16);
        @(negedge clk);
        chk("fill_overflow_pulse", overflow, 0);
        base = we_cnt;
        force_busy = 0;
        for (int j = 0; j < 600 && we_cnt - base < 16; j++) @(negedge clk);
        repeat (40) @(negedge clk);
        chk("fill_drained", we_cnt - base, 16);
        chk("fill_empty", empty, 1);

        force_busy = 1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            wr_en = 1;
            wr_data = 8'h80 + 8'(i);
            @(negedge clk);
        end
        chk("fl_full_before", full, 1);
        flush = 1;
        wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 0;
        flush = 0;
        chk("fl_count", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_overflow", overflow, 0);
        chk("fl_full", full, 0);
        base = we_cnt;
        force_busy = 0;
        repeat (30) @(negedge clk);
        chk("fl_no_issue", we_cnt - base, 0);

        stub_len = 0;
        repeat (10) @(negedge clk);
        t1 = -1;
        t2 = -1;
        wr_en = 1;
        wr_data = 8'hB1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (j == 1) wr_data = 8'hB2;
            if (j == 2) wr_en = 0;
            if (uart_we) begin
                if (t1 < 0) t1 = j;
                else if (t2 < 0) t2 = j;
            end
        end
        chk("to_first_lat", t1, 2);
        chk("to_gap", t2 - t1, 6);

        stub_len = 50;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            wr_en = 1;
            wr_data = 8'hD0 + 8'(i);
            @(negedge clk);
        end
        wr_en = 0;
        repeat (4) @(negedge clk);
        chk("rd_queued", count, 5);
        chk("rd_busy_held", uart_busy, 1);
        reset = 0;
        #1;
        chk("rd_we", uart_we, 0);
        chk("rd_empty", empty, 1);
        chk("rd_count", count, 0);
        chk("rd_data", uart_data, 0);
        @(negedge clk);
        reset = 1;
        stub_len = 0;
        base = we_cnt;
        repeat (20) @(negedge clk);
        chk("rd_no_issue", we_cnt - base, 0);
        wr_en = 1;
        wr_data = 8'hC3;
        @(negedge clk);
        wr_en = 0;
        repeat (5) @(negedge clk);
        chk("rd_new_issue", we_cnt - base, 1);
        repeat (10) @(negedge clk);

        stub_len = $urandom_range(2, 6);
        base = we_cnt;
        sent = 0;
        for (int j = 0; j < 3000 && sent < 40; j++) begin
            ok = ($urandom_range(0, 2) != 0) && count < 12;
            wr_en = ok;
            wr_data = 8'($urandom);
            if (ok) sent++;
            @(negedge clk);
            if (j % 97 == 0) stub_len = $urandom_range(2, 6);
        end
        wr_en = 0;
        for (int j = 0; j < 1000 && we_cnt - base < 40; j++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("rand_sent", sent, 40);
        chk("rand_issued", we_cnt - base, 40);
        chk("rand_empty", empty, 1);
        chk("rand_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
